// File: rtl/vga_timing.sv
// 640x480@60 raster timing from a clock-enable pixel tick; outputs decode the counters in the same cycle.
// No backpressure. Build with VGA_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module vga_timing #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int CLK_DIV  = 2
) (
   input  logic       clk,
   input  logic       reset,
   output logic       pix_tick,
   output logic       hsync,
   output logic       vsync,
   output logic       video_on,
   output logic [9:0] x,
   output logic [9:0] y,
   output logic       line_end,
   output logic       frame_end
`ifdef VGA_TIMING_FRAME_CNT_EN
   ,
   output logic [7:0] frame_cnt
`endif
);

   localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [9:0]       H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0]       V_LAST   = 10'(V_TOTAL - 1);

   generate
      if (H_TOTAL > 1024 || V_TOTAL > 1024 || CLK_DIV < 1) begin : g_bad_cfg
         $error("vga_timing: totals must fit 10-bit counters and CLK_DIV must be >= 1");
      end
   endgenerate

   logic [DIV_W-1:0] div_cnt;
   logic [9:0]       h_cnt;
   logic [9:0]       v_cnt;
   logic             tick;
   logic             h_last;
   logic             v_last;
   logic [10:0]      hx;
   logic [10:0]      vx;
   logic             in_hs;
   logic             in_vs;
   logic             in_act;

   assign tick   = (div_cnt == DIV_LAST) && !reset;
   assign h_last = (h_cnt == H_LAST);
   assign v_last = (v_cnt == V_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         div_cnt <= '0;
         h_cnt   <= '0;
         v_cnt   <= '0;
      end else begin
         div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
         if (tick) begin
            if (h_last) begin
               h_cnt <= '0;
               v_cnt <= v_last ? '0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 10'd1;
            end
         end
      end
   end

   // Decode in 11 bits so a window ending exactly at 1024 still compares correctly.
   assign hx     = {1'b0, h_cnt};
   assign vx     = {1'b0, v_cnt};
   assign in_hs  = (hx >= 11'(HS_START)) && (hx < 11'(HS_END));
   assign in_vs  = (vx >= 11'(VS_START)) && (vx < 11'(VS_END));
   assign in_act = (hx < 11'(H_ACTIVE)) && (vx < 11'(V_ACTIVE));

   // While reset is held the outputs show the post-reset values immediately.
   assign pix_tick  = tick;
   assign hsync     = reset | ~in_hs;
   assign vsync     = reset | ~in_vs;
   assign video_on  = reset | in_act;
   assign x         = reset ? 10'd0 : h_cnt;
   assign y         = reset ? 10'd0 : v_cnt;
   assign line_end  = tick & h_last;
   assign frame_end = tick & h_last & v_last;

`ifdef VGA_TIMING_FRAME_CNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_cnt <= '0;
      end else if (frame_end) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: full-size instance for line-level timing, two shrunken instances for frame-level behaviour.
module tb_vga_timing;

   localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 2;
   localparam int SVA = 4, SVF = 1, SVS = 2, SVB = 1;

   logic clk = 1'b0;
   logic rst_a, rst_b, rst_c;
   bit   started = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;
   int   ka = 0, kb = 0, kc = 0;

   logic       a_pt, a_hs, a_vs, a_von, a_le, a_fe;
   logic [9:0] a_x, a_y;
   logic [7:0] a_fc;
   logic       b_pt, b_hs, b_vs, b_von, b_le, b_fe;
   logic [9:0] b_x, b_y;
   logic [7:0] b_fc;
   logic       c_pt, c_hs, c_vs, c_von, c_le, c_fe;
   logic [9:0] c_x, c_y;
   logic [7:0] c_fc;

   always #5 clk = ~clk;

   vga_timing dut_a (
      .clk(clk), .reset(rst_a), .pix_tick(a_pt), .hsync(a_hs), .vsync(a_vs),
      .video_on(a_von), .x(a_x), .y(a_y), .line_end(a_le), .frame_end(a_fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(a_fc)
`endif
   );

   vga_timing #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CLK_DIV(1)) dut_b (
      .clk(clk), .reset(rst_b), .pix_tick(b_pt), .hsync(b_hs), .vsync(b_vs),
      .video_on(b_von), .x(b_x), .y(b_y), .line_end(b_le), .frame_end(b_fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(b_fc)
`endif
   );

   vga_timing #(.H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
                .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB), .CLK_DIV(3)) dut_c (
      .clk(clk), .reset(rst_c), .pix_tick(c_pt), .hsync(c_hs), .vsync(c_vs),
      .video_on(c_von), .x(c_x), .y(c_y), .line_end(c_le), .frame_end(c_fe)
`ifdef VGA_TIMING_FRAME_CNT_EN
      , .frame_cnt(c_fc)
`endif
   );

`ifndef VGA_TIMING_FRAME_CNT_EN
   assign a_fc = 8'd0;
   assign b_fc = 8'd0;
   assign c_fc = 8'd0;
`endif

   // k = clocks since the cycle in which reset was released; everything follows from it.
   always @(posedge clk) begin
      ka <= rst_a ? 0 : ka + 1;
      kb <= rst_b ? 0 : kb + 1;
      kc <= rst_c ? 0 : kc + 1;
   end

   function automatic logic [33:0] model(input int k, input logic rst,
                                         input int ha, input int hf, input int hs, input int hb,
                                         input int va, input int vf, input int vs, input int vb,
                                         input int d);
      int ht, vt, t, h, v;
      logic pt, hsn, vsn, von, le, fe;
      logic [7:0] fc;
      ht = ha + hf + hs + hb;
      vt = va + vf + vs + vb;
      t  = k / d;
      h  = t % ht;
      v  = (t / ht) % vt;
`ifdef VGA_TIMING_FRAME_CNT_EN
      fc = 8'((t / (ht * vt)) % 256);
`else
      fc = 8'd0;
`endif
      if (rst) return {1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0, 1'b0, 1'b0, fc};
      pt  = ((k % d) == d - 1);
      hsn = !(h >= ha + hf && h < ha + hf + hs);
      vsn = !(v >= va + vf && v < va + vf + vs);
      von = (h < ha) && (v < va);
      le  = pt && (h == ht - 1);
      fe  = le && (v == vt - 1);
      return {pt, hsn, vsn, von, 10'(h), 10'(v), le, fe, fc};
   endfunction

   task automatic check(input string name, input logic [33:0] got, input logic [33:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (started) begin
         check("model_a", {a_pt, a_hs, a_vs, a_von, a_x, a_y, a_le, a_fe, a_fc},
               model(ka, rst_a, 640, 16, 96, 48, 480, 10, 2, 33, 2));
         check("model_b", {b_pt, b_hs, b_vs, b_von, b_x, b_y, b_le, b_fe, b_fc},
               model(kb, rst_b, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 1));
         check("model_c", {c_pt, c_hs, c_vs, c_von, c_x, c_y, c_le, c_fe, c_fc},
               model(kc, rst_c, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, 3));
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_a = 1'b1;
      rst_b = 1'b1;
      rst_c = 1'b1;
      @(posedge clk);
      started = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst_a = 1'b0;
      rst_b = 1'b0;
      rst_c = 1'b0;
      fork
         begin : proc_a
            int hs_first, hs_n, le_n, le_at;
            hs_first = -1; hs_n = 0; le_n = 0; le_at = -1;
            for (int i = 0; i < 3300; i++) begin
               @(negedge clk);
               if (i == 0)
                  check("a_reset_exit", {a_pt, a_x, a_y, a_von, a_hs, a_vs},
                        {1'b0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1});
               if (i == 1) check("a_first_tick", a_pt, 1'b1);
               if (i < 1600) begin
                  if (!a_hs) begin
                     if (hs_first < 0) hs_first = i;
                     hs_n++;
                  end
                  if (a_le) begin
                     le_n++;
                     le_at = i;
                  end
               end
               if (i == 1600) check("a_next_line", {a_x, a_y}, {10'd0, 10'd1});
            end
            check("a_hsync_start", 34'(hs_first), 34'd1312);
            check("a_hsync_len", 34'(hs_n), 34'd192);
            check("a_line_end_cnt", 34'(le_n), 34'd1);
            check("a_line_end_at", 34'(le_at), 34'd1599);
            repeat ($urandom_range(1, 400)) @(posedge clk);
            #1 rst_a = 1'b1;
            @(posedge clk);
            #1 rst_a = 1'b0;
            @(negedge clk);
            check("a_reset_mid", {a_x, a_y, a_hs, a_le, a_fe},
                  {10'd0, 10'd0, 1'b1, 1'b0, 1'b0});
            repeat (300) @(negedge clk);
         end
         begin : proc_b
            int fe_at, von_n, fe_n;
            for (int i = 0; i < 3000; i++) begin
               @(posedge clk);
               #1;
               rst_b = ($urandom_range(0, 199) == 0);
               rst_c = ($urandom_range(0, 149) == 0);
            end
            @(posedge clk);
            #1 rst_b = 1'b1; rst_c = 1'b0;
            @(posedge clk);
            #1 rst_b = 1'b0;
            repeat (41) @(posedge clk);
            @(negedge clk);
            check("b_pre_reset_pos", {b_x, b_y}, {10'd11, 10'd2});
            @(posedge clk);
            #1 rst_b = 1'b1;
            @(posedge clk);
            #1 rst_b = 1'b0;
            @(negedge clk);
            check("b_after_reset", {b_x, b_y, b_hs, b_le, b_fe},
                  {10'd0, 10'd0, 1'b1, 1'b0, 1'b0});
            fe_at = -1; von_n = 0;
            for (int n = 0; n < 1000; n++) begin
               if (n > 0) @(negedge clk);
               if (b_pt && b_von) von_n++;
               if (b_fe) begin
                  fe_at = n;
                  break;
               end
            end
            check("b_first_frame_end", 34'(fe_at), 34'd119);
            check("b_active_ticks", 34'(von_n), 34'd32);
            fe_n = 1;
            for (int n = 0; n < 40000 && fe_n < 257; n++) begin
               @(negedge clk);
               if (b_fe) fe_n++;
            end
            check("b_frames_seen", 34'(fe_n), 34'd257);
            @(negedge clk);
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("b_frame_cnt_wrap", b_fc, 8'd1);
`else
            check("b_frame_restart", {b_x, b_y}, {10'd0, 10'd0});
`endif
            @(posedge clk);
            #1 rst_b = 1'b1;
            @(posedge clk);
            #1 rst_b = 1'b0;
            @(negedge clk);
`ifdef VGA_TIMING_FRAME_CNT_EN
            check("b_frame_cnt_clear", b_fc, 8'd0);
`else
            check("b_reset_clear", {b_x, b_y, b_pt}, {10'd0, 10'd0, 1'b1});
`endif
         end
      join
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
